pc_ctrl: RTL and testbench

Fetch-stage controller that sequences the PC register of the pipelined CPU. It selects the next PC from sequential, branch and jump sources, and generates the register's `stall_i` and `PCWrite_i` controls from cache-miss stalls and load-use hazards. It also holds a redirect that arrives during a cache stall until the stall releases, and counts lost fetch cycles.

---
 rtl/pc_ctrl_pkg.sv | 15 +
 rtl/pc_ctrl_redirect_hold.sv | 34 +++
 rtl/pc_ctrl.sv | 114 +++++++++++
 tb/tb_pc_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the fetch-stage PC controller and the hazard unit.
// Holds the controller state encoding and the default datapath widths.
package pc_ctrl_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int CNT_W_DEF  = 16;
  localparam int PC_INC_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_MISS = 2'd2
  } state_e;

endpackage

// File: rtl/pc_ctrl_redirect_hold.sv
// Parks a branch/jump target that arrived while fetch was frozen by a cache miss,
// so it can be applied on the first cycle the PC is allowed to move again.
module redirect_hold #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            capture_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] tgt_i,
  output logic            valid_o,
  output logic [XLEN-1:0] tgt_o
);

  logic            valid_reg;
  logic [XLEN-1:0] tgt_reg;

  // Clear outranks capture so leaving the run state always drops the hold.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_reg <= 1'b0;
      tgt_reg   <= '0;
    end else if (clear_i) begin
      valid_reg <= 1'b0;
    end else if (capture_i) begin
      valid_reg <= 1'b1;
      tgt_reg   <= tgt_i;
    end
  end

  assign valid_o = valid_reg;
  assign tgt_o   = tgt_reg;

endmodule

// File: rtl/pc_ctrl.sv
// Fetch-stage PC controller: next-PC selection, PC write/stall/flush generation,
// redirect hold across cache misses and a saturating lost-fetch-cycle counter.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PC_INC = PC_INC_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic             icache_stall_i,
  input  logic             dcache_stall_i,
  input  logic             hazard_i,
  input  logic             branch_i,
  input  logic [XLEN-1:0]  branch_tgt_i,
  input  logic             jump_i,
  input  logic [XLEN-1:0]  jump_tgt_i,
  output logic [XLEN-1:0]  pc_next_o,
  output logic             pc_write_o,
  output logic             stall_o,
  output logic             flush_o,
  output logic             pend_o,
  output logic [CNT_W-1:0] lost_cnt_o
);

  state_e           state_reg, state_next;
  logic             mem_stall;
  logic             active;
  logic             redir;
  logic [XLEN-1:0]  tgt;
  logic             hold_valid;
  logic [XLEN-1:0]  hold_tgt;
  logic             hold_capture;
  logic             hold_clear;
  logic [CNT_W-1:0] lost_reg;

  assign mem_stall = icache_stall_i | dcache_stall_i;
  assign active    = (state_reg != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start_i) state_next = ST_RUN;
      ST_RUN: begin
        if (!start_i)       state_next = ST_IDLE;
        else if (mem_stall) state_next = ST_MISS;
      end
      ST_MISS: begin
        if (!start_i)        state_next = ST_IDLE;
        else if (!mem_stall) state_next = ST_RUN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Oldest redirect wins: held one, then EX branch, then ID jump.
  always_comb begin
    redir = 1'b0;
    tgt   = '0;
    if (hold_valid) begin
      redir = 1'b1;
      tgt   = hold_tgt;
    end else if (branch_i) begin
      redir = 1'b1;
      tgt   = branch_tgt_i;
    end else if (jump_i) begin
      redir = 1'b1;
      tgt   = jump_tgt_i;
    end
  end

  assign pc_next_o  = redir ? tgt : pc_i + XLEN'(PC_INC);
  assign stall_o    = active & mem_stall;
  assign pc_write_o = active & start_i & ~mem_stall & (~hazard_i | redir);
  assign flush_o    = pc_write_o & redir;
  assign pend_o     = hold_valid;

  assign hold_capture = active & mem_stall & ~hold_valid & (branch_i | jump_i);
  assign hold_clear   = pc_write_o | (active & ~start_i);

  redirect_hold #(
    .XLEN (XLEN)
  ) u_hold (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .capture_i (hold_capture),
    .clear_i   (hold_clear),
    .tgt_i     (branch_i ? branch_tgt_i : jump_tgt_i),
    .valid_o   (hold_valid),
    .tgt_o     (hold_tgt)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      lost_reg <= '0;
    end else if (active && start_i && !pc_write_o && (lost_reg != {CNT_W{1'b1}})) begin
      lost_reg <= lost_reg + CNT_W'(1);
    end
  end

  assign lost_cnt_o = lost_reg;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_pc_ctrl;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic [31:0] pc_i;
  logic        icache_stall_i;
  logic        dcache_stall_i;
  logic        hazard_i;
  logic        branch_i;
  logic [31:0] branch_tgt_i;
  logic        jump_i;
  logic [31:0] jump_tgt_i;

  logic [31:0] pc_next_o,  pc_next4;
  logic        pc_write_o, pc_write4;
  logic        stall_o,    stall4;
  logic        flush_o,    flush4;
  logic        pend_o,     pend4;
  logic [15:0] lost_cnt_o;
  logic [3:0]  lost_cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  pc_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .pc_i(pc_i),
    .icache_stall_i(icache_stall_i), .dcache_stall_i(dcache_stall_i),
    .hazard_i(hazard_i), .branch_i(branch_i), .branch_tgt_i(branch_tgt_i),
    .jump_i(jump_i), .jump_tgt_i(jump_tgt_i),
    .pc_next_o(pc_next_o), .pc_write_o(pc_write_o), .stall_o(stall_o),
    .flush_o(flush_o), .pend_o(pend_o), .lost_cnt_o(lost_cnt_o)
  );

  pc_ctrl #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .pc_i(pc_i),
    .icache_stall_i(icache_stall_i), .dcache_stall_i(dcache_stall_i),
    .hazard_i(hazard_i), .branch_i(branch_i), .branch_tgt_i(branch_tgt_i),
    .jump_i(jump_i), .jump_tgt_i(jump_tgt_i),
    .pc_next_o(pc_next4), .pc_write_o(pc_write4), .stall_o(stall4),
    .flush_o(flush4), .pend_o(pend4), .lost_cnt_o(lost_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: only "is the CPU running", the parked redirect and the counts matter.
  bit          model_valid = 0;
  bit          run_m = 0;
  bit          hv_m = 0;
  logic [31:0] ht_m = '0;
  int          lost16_m = 0;
  int          lost4_m = 0;

  function automatic bit m_mem();
    return icache_stall_i | dcache_stall_i;
  endfunction

  function automatic bit m_redir();
    return hv_m | branch_i | jump_i;
  endfunction

  function automatic logic [31:0] m_next();
    logic [31:0] seq;
    seq = pc_i + 32'd4;
    if (hv_m)     return ht_m;
    if (branch_i) return branch_tgt_i;
    if (jump_i)   return jump_tgt_i;
    return seq;
  endfunction

  function automatic bit m_pw();
    return run_m && start_i && !m_mem() && (!hazard_i || m_redir());
  endfunction

  always @(posedge clk) begin
    if (!rst_i) begin
      run_m       <= 0;
      hv_m        <= 0;
      lost16_m    <= 0;
      lost4_m     <= 0;
      model_valid <= 1;
    end else begin
      if (!run_m) begin
        run_m <= start_i;
      end else if (!start_i) begin
        run_m <= 0;
        hv_m  <= 0;
      end else if (m_pw() && hv_m) begin
        hv_m <= 0;
      end else if (m_mem() && !hv_m && (branch_i || jump_i)) begin
        hv_m <= 1;
        ht_m <= branch_i ? branch_tgt_i : jump_tgt_i;
      end
      if (run_m && start_i && !m_pw()) begin
        lost16_m <= (lost16_m >= 65535) ? 65535 : lost16_m + 1;
        lost4_m  <= (lost4_m  >= 15)    ? 15    : lost4_m + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("m_pc_next",  pc_next_o,           m_next());
      chk("m_pc_write", 32'(pc_write_o),     32'(m_pw()));
      chk("m_stall",    32'(stall_o),        32'(run_m && m_mem()));
      chk("m_flush",    32'(flush_o),        32'(m_pw() && m_redir()));
      chk("m_pend",     32'(pend_o),         32'(hv_m));
      chk("m_lost16",   32'(lost_cnt_o),     32'(lost16_m));
      chk("m_lost4",    32'(lost_cnt4),      32'(lost4_m));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    hazard_i = 0; branch_i = 0; jump_i = 0;
    icache_stall_i = 0; dcache_stall_i = 0;
  endtask

  initial begin
    rst_i = 0; start_i = 0; pc_i = 32'h100;
    branch_tgt_i = 0; jump_tgt_i = 0;
    quiet();
    cyc(); cyc();

    $display("[TB] step reset then start");
    rst_i = 1; start_i = 1;
    @(negedge clk);
    chk("rst_pw",    32'(pc_write_o), 0);
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_flush", 32'(flush_o), 0);
    chk("rst_pend",  32'(pend_o), 0);
    chk("rst_lost",  32'(lost_cnt_o), 0);
    chk("rst_next",  pc_next_o, 32'h104);
    cyc();
    @(negedge clk);
    chk("run_pw",   32'(pc_write_o), 1);
    chk("run_next", pc_next_o, 32'h104);
    chk("run_lost", 32'(lost_cnt_o), 0);

    $display("[TB] step hazard bubble");
    cyc(); hazard_i = 1;
    @(negedge clk);
    chk("haz_pw", 32'(pc_write_o), 0);
    cyc(); hazard_i = 0;
    @(negedge clk);
    chk("haz_lost", 32'(lost_cnt_o), 1);

    $display("[TB] step hazard with branch");
    cyc(); hazard_i = 1; branch_i = 1; branch_tgt_i = 32'h200;
    @(negedge clk);
    chk("hb_pw",    32'(pc_write_o), 1);
    chk("hb_next",  pc_next_o, 32'h200);
    chk("hb_flush", 32'(flush_o), 1);

    $display("[TB] step miss with held redirect");
    cyc(); hazard_i = 0; icache_stall_i = 1; branch_i = 1; branch_tgt_i = 32'h300;
    @(negedge clk);
    chk("miss1_stall", 32'(stall_o), 1);
    chk("miss1_pend",  32'(pend_o), 0);
    chk("miss1_pw",    32'(pc_write_o), 0);
    for (int i = 2; i <= 5; i++) begin
      cyc(); branch_i = 0;
      @(negedge clk);
      chk("missn_stall", 32'(stall_o), 1);
      chk("missn_pend",  32'(pend_o), 1);
    end
    cyc(); icache_stall_i = 0;
    @(negedge clk);
    chk("rel_next",  pc_next_o, 32'h300);
    chk("rel_flush", 32'(flush_o), 1);
    chk("rel_pw",    32'(pc_write_o), 1);
    chk("rel_lost",  32'(lost_cnt_o), 6);  // one hazard bubble plus five miss cycles

    $display("[TB] step branch and jump together");
    cyc(); branch_i = 1; branch_tgt_i = 32'h400; jump_i = 1; jump_tgt_i = 32'h500;
    @(negedge clk);
    chk("bj_pend",  32'(pend_o), 0);
    chk("bj_next",  pc_next_o, 32'h400);
    chk("bj_flush", 32'(flush_o), 1);

    $display("[TB] step pc wrap");
    cyc(); branch_i = 0; jump_i = 0; pc_i = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("wrap_next", pc_next_o, 32'h0);

    $display("[TB] step counter saturation");
    cyc(); dcache_stall_i = 1;
    repeat (19) cyc();
    cyc(); dcache_stall_i = 0;
    @(negedge clk);
    chk("sat_lost4",  32'(lost_cnt4), 15);
    chk("sat_lost16", 32'(lost_cnt_o), 26);

    $display("[TB] step reset mid-miss with held redirect");
    cyc(); icache_stall_i = 1; branch_i = 1; branch_tgt_i = 32'h600;
    @(negedge clk);
    chk("pre_stall", 32'(stall_o), 1);
    cyc(); branch_i = 0;
    @(negedge clk);
    chk("pre_pend", 32'(pend_o), 1);
    cyc(); rst_i = 0;
    cyc(); rst_i = 1;
    @(negedge clk);
    chk("mrst_pw",     32'(pc_write_o), 0);
    chk("mrst_stall",  32'(stall_o), 0);
    chk("mrst_flush",  32'(flush_o), 0);
    chk("mrst_pend",   32'(pend_o), 0);
    chk("mrst_lost",   32'(lost_cnt_o), 0);
    chk("mrst_lost4",  32'(lost_cnt4), 0);
    chk("mrst_next",   pc_next_o, 32'h0);

    $display("[TB] step randomized traffic");
    quiet();
    for (int n = 0; n < 4000; n++) begin
      cyc();
      rst_i          = ($urandom_range(0, 199) != 0);
      start_i        = ($urandom_range(0, 39) != 0);
      pc_i           = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      if ($urandom_range(0, 5) == 0) icache_stall_i = ~icache_stall_i;
      if ($urandom_range(0, 7) == 0) dcache_stall_i = ~dcache_stall_i;
      hazard_i       = ($urandom_range(0, 4) == 0);
      branch_i       = ($urandom_range(0, 5) == 0);
      jump_i         = ($urandom_range(0, 5) == 0);
      branch_tgt_i   = $urandom() & 32'hFFFF_FFFC;
      jump_tgt_i     = $urandom() & 32'hFFFF_FFFC;
    end
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
